// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: widths, rotation table, PC-2 table and FSM states.
package des_pkg;

  localparam int unsigned HALF_W   = 28;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned KEY_W    = 56;
  localparam int unsigned ROUND_W  = 4;

  localparam logic [ROUND_W-1:0] LAST_ROUND = 4'd15;

  typedef enum logic {IDLE, RUN} state_t;

  // Left-rotation amount applied to reach round 1..16 (index 0 = round 1).
  localparam logic [1:0] SHIFT_TABLE [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // PC-2 source positions, 1-based into {D,C} (DES bit 1 = index 0).
  localparam int unsigned PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // DES left rotate: DES bit 2 moves to bit 1, i.e. towards index 0.
  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

endpackage

// File: rtl/key_permutation2.sv
// Combinational DES PC-2: selects 48 of the 56 {D,C} bits, index 0 = DES bit 1 on both sides.
module key_permutation2
  import des_pkg::*;
(
  input  logic [KEY_W-1:0]    cd,
  output logic [SUBKEY_W-1:0] subkey
);

  for (genvar j = 0; j < SUBKEY_W; j++) begin : g_pc2
    assign subkey[j] = cd[6'(PC2_TABLE[j] - 1)];
  end

  // PC-2 drops DES bits 9, 18, 22, 25, 35, 38, 43 and 54.
  logic unused_bits;
  assign unused_bits = ^{cd[8], cd[17], cd[21], cd[24], cd[34], cd[37], cd[42], cd[53]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES round-subkey generator, one subkey per accepted next, encrypt or decrypt order.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [KEY_W-1:0]    key56,
  input  logic                decrypt,
  input  logic                next,
  output logic [SUBKEY_W-1:0] subkey,
  output logic [ROUND_W-1:0]  round,
  output logic                subkey_valid,
  output logic                done
);

  state_t              state, state_nxt;
  logic [HALF_W-1:0]   c, d, c_nxt, d_nxt;
  logic [ROUND_W-1:0]  round_nxt;
  logic                valid_nxt, done_nxt;
  logic                dec_q, dec_nxt;
  logic                rot_two_enc, rot_two_dec;

  // Encrypt steps forward through the table, decrypt walks it backwards.
  assign rot_two_enc = (SHIFT_TABLE[round + ROUND_W'(1)] == 2'd2);
  assign rot_two_dec = (SHIFT_TABLE[LAST_ROUND - round] == 2'd2);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      c            <= '0;
      d            <= '0;
      round        <= '0;
      subkey_valid <= 1'b0;
      done         <= 1'b0;
      dec_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      c            <= c_nxt;
      d            <= d_nxt;
      round        <= round_nxt;
      subkey_valid <= valid_nxt;
      done         <= done_nxt;
      dec_q        <= dec_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    c_nxt     = c;
    d_nxt     = d;
    round_nxt = round;
    valid_nxt = subkey_valid;
    done_nxt  = 1'b0;
    dec_nxt   = dec_q;

    if (start) begin
      // Encrypt preloads the round-1 rotation so K1 is ready immediately.
      state_nxt = RUN;
      round_nxt = '0;
      valid_nxt = 1'b1;
      dec_nxt   = decrypt;
      c_nxt     = decrypt ? key56[HALF_W-1:0] : rotl(key56[HALF_W-1:0], 1'b0);
      d_nxt     = decrypt ? key56[KEY_W-1:HALF_W] : rotl(key56[KEY_W-1:HALF_W], 1'b0);
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          if (next) begin
            // Decrypt also rotates on the final accept so C/D return to C0/D0.
            if (dec_q) begin
              c_nxt = rotr(c, rot_two_dec);
              d_nxt = rotr(d, rot_two_dec);
            end else if (round != LAST_ROUND) begin
              c_nxt = rotl(c, rot_two_enc);
              d_nxt = rotl(d, rot_two_enc);
            end
            if (round == LAST_ROUND) begin
              state_nxt = IDLE;
              round_nxt = '0;
              valid_nxt = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              round_nxt = round + ROUND_W'(1);
            end
          end
        end
      endcase
    end
  end

  key_permutation2 u_pc2 (
    .cd     ({d, c}),
    .subkey (subkey)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule against a closed-form DES key-schedule model.
module tb_des_key_schedule;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [55:0] key56;
  logic        decrypt;
  logic        next;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        subkey_valid;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [47:0] key;
    logic [3:0]  rnd;
  } exp_t;

  exp_t q[$];
  logic done_exp = 1'b0;

  int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  des_key_schedule dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .key56        (key56),
    .decrypt      (decrypt),
    .next         (next),
    .subkey       (subkey),
    .round        (round),
    .subkey_valid (subkey_valid),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal bit strings are written DES bit 1 first; reverse into index order.
  function automatic logic [47:0] rev48(input logic [47:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[i] = x[47-i];
    return r;
  endfunction

  function automatic logic [27:0] rev28(input logic [27:0] x);
    logic [27:0] r;
    for (int i = 0; i < 28; i++) r[i] = x[27-i];
    return r;
  endfunction

  // Kr = PC-2 of C0/D0 rotated left by the cumulative shift up to round r (1..16).
  function automatic logic [47:0] model_key(input logic [55:0] k, input int r);
    int          s;
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] sk;
    s = 0;
    for (int i = 0; i < r; i++) s += shifts[i];
    for (int j = 0; j < 28; j++) begin
      c[j] = k[(j + s) % 28];
      d[j] = k[28 + ((j + s) % 28)];
    end
    cd = {d, c};
    for (int j = 0; j < 48; j++) sk[j] = cd[pc2[j] - 1];
    return sk;
  endfunction

  task automatic push_schedule(input logic [55:0] k, input logic dec);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.key = model_key(k, dec ? (16 - i) : (i + 1));
      e.rnd = 4'(i);
      q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that sampled start.
  task automatic do_start(input logic [55:0] k, input logic dec);
    key56   = k;
    decrypt = dec;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    decrypt = ~dec;
    q.delete();
    push_schedule(k, dec);
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (round !== r && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_round_reached", 64'(round), 64'(r));
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  // Monitor: compares the queue head every cycle, pops on each accepted next.
  always @(negedge clk) begin
    check("done", 64'(done), 64'(done_exp));
    check("subkey_valid", 64'(subkey_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("subkey", 64'(subkey), 64'(q[0].key));
      check("round", 64'(round), 64'(q[0].rnd));
    end
    done_exp = 1'b0;
    if (n_rst && !start && next && q.size() != 0) begin
      void'(q.pop_front());
      if (q.size() == 0) done_exp = 1'b1;
    end
    if (!n_rst) done_exp = 1'b0;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] kk, k1, k2;
    logic [47:0] k1_lit, k16_lit;
    logic        dec;

    kk      = {rev28(28'b0101010101100110011110001111), rev28(28'b1111000011001100101010101111)};
    k1_lit  = rev48(48'b000110110000001011101111111111000111000001110010);
    k16_lit = rev48(48'b110010110011110110001011000011100001011111110101);

    n_rst = 1'b0; start = 1'b0; next = 1'b0; decrypt = 1'b0; key56 = '0;
    #1;
    check("rst_valid", 64'(subkey_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_round", 64'(round), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;

    // next in IDLE is ignored
    next = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_round", 64'(round), 64'd0);
    check("idle_subkey", 64'(subkey), 64'd0);
    next = 1'b0;

    // Known-key encrypt schedule
    do_start(kk, 1'b0);
    check("enc_k1_literal", 64'(subkey), 64'(k1_lit));
    check("enc_k1_round", 64'(round), 64'd0);
    next = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("enc_k16_round", 64'(round), 64'd15);
    check("enc_k16_literal", 64'(subkey), 64'(k16_lit));
    @(posedge clk);
    #1;
    next = 1'b0;
    check("enc_done_pulse", 64'(done), 64'd1);
    check("enc_valid_low", 64'(subkey_valid), 64'd0);
    @(posedge clk);
    #1;
    check("enc_done_single", 64'(done), 64'd0);

    // Known-key decrypt schedule
    do_start(kk, 1'b1);
    check("dec_first_is_k16", 64'(subkey), 64'(k16_lit));
    next = 1'b1;
    wait_done(40);
    next = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Random keys with random stalls
    for (int t = 0; t < 8; t++) begin
      k1  = {$urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      do_start(k1, dec);
      for (int n = 0; n < 400; n++) begin
        next = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        if (done) break;
      end
      check("stall_done_seen", 64'(done), 64'd1);
      next = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Restart at round 7 with a new key; concurrent next ignored
    k1 = {$urandom, $urandom};
    k2 = {$urandom, $urandom};
    do_start(k1, 1'b0);
    next = 1'b1;
    wait_round(4'd7);
    dec = 1'($urandom_range(0, 1));
    do_start(k2, dec);
    check("restart_round", 64'(round), 64'd0);
    check("restart_subkey", 64'(subkey), 64'(model_key(k2, dec ? 16 : 1)));
    wait_done(40);
    next = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset at round 10
    k1 = {$urandom, $urandom};
    do_start(k1, 1'b1);
    next = 1'b1;
    wait_round(4'd10);
    #2;
    n_rst = 1'b0;
    q.delete();
    next = 1'b0;
    #1;
    check("async_rst_valid", 64'(subkey_valid), 64'd0);
    check("async_rst_round", 64'(round), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_subkey", 64'(subkey), 64'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 64'(subkey_valid), 64'd0);

    // Final full encrypt run after reset
    k1 = {$urandom, $urandom};
    do_start(k1, 1'b0);
    next = 1'b1;
    wait_done(40);
    next = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
